cache_perf_monitor: RTL and testbench

CACHE_PERF_MONITOR -- requirements
Module: cache_perf_monitor

---
 rtl/cache_perf_pkg.sv | 22 ++
 rtl/rate_divider.sv | 92 +++++++++
 rtl/cache_perf_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_perf_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_perf_pkg.sv
// -----------------------------------------------------------------------------
// cache_perf_pkg
// Shared definitions for the cache performance monitor: the sequencing FSM
// state encoding and the constants of the hit-rate computation.
//   PCT_W     : width of a percentage result (0..100 fits in 7 bits)
//   SCALE     : multiplier turning a hit fraction into a percentage
//   DIV_ITERS : number of restoring-division iterations (one per quotient bit)
// -----------------------------------------------------------------------------
package cache_perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam int PCT_W     = 7;
    localparam int SCALE     = 100;
    localparam int DIV_ITERS = 7;

endpackage

// File: rtl/rate_divider.sv
// -----------------------------------------------------------------------------
// rate_divider
// Multi-cycle restoring divider producing a PCT_W-bit quotient.
// A start pulse loads numerator/denominator; DIV_ITERS edges later the result
// is ready and done pulses for one cycle. The quotient must fit in PCT_W bits,
// which holds because numerator = hits*100 and hits <= denominator.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : load operands and begin a division
//   numerator    : NUM_W-bit dividend
//   denominator  : DEN_W-bit divisor
//   done         : one-cycle pulse, quotient/nodata valid
//   quotient     : floor(numerator/denominator), forced to 0 when nodata
//   nodata       : denominator was zero
// -----------------------------------------------------------------------------
module rate_divider
    import cache_perf_pkg::*;
#(
    parameter int NUM_W = 39,
    parameter int DEN_W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             done,
    output logic [PCT_W-1:0] quotient,
    output logic             nodata
);

    localparam int ITER_W = 3;

    logic [NUM_W-1:0]  rem_q, rem_d;
    logic [NUM_W-1:0]  dvs_q, dvs_d;
    logic [PCT_W-1:0]  quo_q, quo_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              done_q, done_d;
    logic              nodata_q, nodata_d;

    // The divisor starts aligned with the most significant quotient bit and is
    // shifted right once per iteration, so the dividend never needs shifting.
    always_comb begin
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        iter_d   = iter_q;
        done_d   = 1'b0;
        nodata_d = nodata_q;
        if (start) begin
            rem_d    = numerator;
            dvs_d    = NUM_W'(denominator) << (DIV_ITERS - 1);
            quo_d    = '0;
            iter_d   = ITER_W'(DIV_ITERS);
            nodata_d = (denominator == '0);
        end else if (iter_q != '0) begin
            if (rem_q >= dvs_q) begin
                rem_d = rem_q - dvs_q;
                quo_d = {quo_q[PCT_W-2:0], 1'b1};
            end else begin
                quo_d = {quo_q[PCT_W-2:0], 1'b0};
            end
            dvs_d  = dvs_q >> 1;
            iter_d = iter_q - ITER_W'(1);
            done_d = (iter_q == ITER_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            iter_q   <= '0;
            done_q   <= 1'b0;
            nodata_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            iter_q   <= iter_d;
            done_q   <= done_d;
            nodata_q <= nodata_d;
        end
    end

    // A zero divisor makes every compare succeed; mask that garbage quotient.
    assign done     = done_q;
    assign quotient = nodata_q ? '0 : quo_q;
    assign nodata   = nodata_q;

endmodule

// File: rtl/cache_perf_monitor.sv
// -----------------------------------------------------------------------------
// cache_perf_monitor
// Counts hits and misses per cache level for a hierarchical lookup (level i is
// only consulted when every lower level missed) and, on request, computes the
// hit rate of each level in percent from a snapshot of the counters.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   access_valid  : a lookup is presented this cycle
//   hit_vec       : per-level hit flags, sampled with access_valid
//   clear         : synchronous zeroing of the live counters (wins over access)
//   snap_req      : take a snapshot and compute rates (ignored while busy)
//   hit_cnt       : per-level saturating hit counters, level 0 in LSBs
//   miss_cnt      : per-level saturating miss counters, level 0 in LSBs
//   busy          : rate computation in progress
//   rate_valid    : one-cycle pulse qualifying rate_level/rate_pct/rate_nodata
//   rate_level    : level of the current result
//   rate_pct      : floor(hits*100/(hits+misses))
//   rate_nodata   : level saw no lookups in the snapshot
// -----------------------------------------------------------------------------
module cache_perf_monitor
    import cache_perf_pkg::*;
#(
    parameter int NUM_LEVELS = 2,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        access_valid,
    input  logic [NUM_LEVELS-1:0]       hit_vec,
    input  logic                        clear,
    input  logic                        snap_req,
    output logic [NUM_LEVELS*CNT_W-1:0] hit_cnt,
    output logic [NUM_LEVELS*CNT_W-1:0] miss_cnt,
    output logic                        busy,
    output logic                        rate_valid,
    output logic [2:0]                  rate_level,
    output logic [PCT_W-1:0]            rate_pct,
    output logic                        rate_nodata
);

    localparam int              NUM_W    = CNT_W + PCT_W;
    localparam int              DEN_W    = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [2:0]      LAST_LVL = 3'(NUM_LEVELS - 1);

    state_t           state_q, state_d;
    logic [2:0]       lvl_q, lvl_d;
    logic [2:0]       div_cnt_q, div_cnt_d;
    logic             busy_q, busy_d;
    logic             rate_valid_q, rate_valid_d;
    logic [2:0]       rate_level_q, rate_level_d;
    logic [PCT_W-1:0] rate_pct_q, rate_pct_d;
    logic             rate_nodata_q, rate_nodata_d;

    logic                        snap_take;
    logic [NUM_LEVELS-1:0]       prior_miss;
    logic [NUM_LEVELS-1:0]       lookup;
    logic [NUM_LEVELS*CNT_W-1:0] snap_hit_flat;
    logic [NUM_LEVELS*CNT_W-1:0] snap_miss_flat;

    logic [CNT_W-1:0] sel_hit, sel_miss;
    logic [NUM_W-1:0] div_num;
    logic [DEN_W-1:0] div_den;
    logic             div_start, div_done, div_nodata;
    logic [PCT_W-1:0] div_quo;

    // The snapshot is taken on exactly the edge that accepts the request.
    assign snap_take = (state_q == IDLE) && snap_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
            logic [CNT_W-1:0] hit_q, hit_d;
            logic [CNT_W-1:0] miss_q, miss_d;
            logic [CNT_W-1:0] snap_hit_q, snap_hit_d;
            logic [CNT_W-1:0] snap_miss_q, snap_miss_d;

            // Level gi is consulted only when every lower level missed.
            if (gi == 0) begin : g_first
                assign prior_miss[gi] = 1'b1;
            end else begin : g_upper
                assign prior_miss[gi] = prior_miss[gi-1] & ~hit_vec[gi-1];
            end
            assign lookup[gi] = access_valid & prior_miss[gi];

            always_comb begin
                hit_d  = hit_q;
                miss_d = miss_q;
                if (clear) begin
                    hit_d  = '0;
                    miss_d = '0;
                end else if (lookup[gi]) begin
                    if (hit_vec[gi]) begin
                        if (hit_q != CNT_MAX) hit_d = hit_q + CNT_W'(1);
                    end else begin
                        if (miss_q != CNT_MAX) miss_d = miss_q + CNT_W'(1);
                    end
                end
                snap_hit_d  = snap_take ? hit_q  : snap_hit_q;
                snap_miss_d = snap_take ? miss_q : snap_miss_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hit_q       <= '0;
                    miss_q      <= '0;
                    snap_hit_q  <= '0;
                    snap_miss_q <= '0;
                end else begin
                    hit_q       <= hit_d;
                    miss_q      <= miss_d;
                    snap_hit_q  <= snap_hit_d;
                    snap_miss_q <= snap_miss_d;
                end
            end

            assign hit_cnt[gi*CNT_W +: CNT_W]        = hit_q;
            assign miss_cnt[gi*CNT_W +: CNT_W]       = miss_q;
            assign snap_hit_flat[gi*CNT_W +: CNT_W]  = snap_hit_q;
            assign snap_miss_flat[gi*CNT_W +: CNT_W] = snap_miss_q;
        end
    endgenerate

    // Operands of the level currently being processed.
    always_comb begin
        sel_hit  = '0;
        sel_miss = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (lvl_q == 3'(i)) begin
                sel_hit  = snap_hit_flat[i*CNT_W +: CNT_W];
                sel_miss = snap_miss_flat[i*CNT_W +: CNT_W];
            end
        end
    end

    assign div_num   = NUM_W'(sel_hit) * NUM_W'(SCALE);
    assign div_den   = DEN_W'(sel_hit) + DEN_W'(sel_miss);
    assign div_start = (state_q == LOAD);

    rate_divider #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_rate_divider (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .numerator   (div_num),
        .denominator (div_den),
        .done        (div_done),
        .quotient    (div_quo),
        .nodata      (div_nodata)
    );

    // Sequencer: each level takes LOAD (1) + DIV (DIV_ITERS) + EMIT (1) cycles,
    // so the result of level j appears 9*(j+1) edges after the request.
    always_comb begin
        state_d       = state_q;
        lvl_d         = lvl_q;
        div_cnt_d     = div_cnt_q;
        busy_d        = busy_q;
        rate_valid_d  = 1'b0;
        rate_level_d  = rate_level_q;
        rate_pct_d    = rate_pct_q;
        rate_nodata_d = rate_nodata_q;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    state_d = LOAD;
                    lvl_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d   = DIV;
                div_cnt_d = '0;
            end
            DIV: begin
                if (div_cnt_q == 3'(DIV_ITERS - 1)) begin
                    state_d = EMIT;
                end else begin
                    div_cnt_d = div_cnt_q + 3'd1;
                end
            end
            EMIT: begin
                rate_valid_d  = div_done;
                rate_level_d  = lvl_q;
                rate_pct_d    = div_quo;
                rate_nodata_d = div_nodata;
                if (lvl_q == LAST_LVL) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = LOAD;
                    lvl_d   = lvl_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lvl_q         <= '0;
            div_cnt_q     <= '0;
            busy_q        <= 1'b0;
            rate_valid_q  <= 1'b0;
            rate_level_q  <= '0;
            rate_pct_q    <= '0;
            rate_nodata_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lvl_q         <= lvl_d;
            div_cnt_q     <= div_cnt_d;
            busy_q        <= busy_d;
            rate_valid_q  <= rate_valid_d;
            rate_level_q  <= rate_level_d;
            rate_pct_q    <= rate_pct_d;
            rate_nodata_q <= rate_nodata_d;
        end
    end

    assign busy        = busy_q;
    assign rate_valid  = rate_valid_q;
    assign rate_level  = rate_level_q;
    assign rate_pct    = rate_pct_q;
    assign rate_nodata = rate_nodata_q;

endmodule

// File: tb/tb_cache_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_cache_perf_monitor
// Directed bench: a 2-level / 32-bit monitor for counting, rates, clear,
// back-to-back requests and reset, plus a 2-level / 8-bit monitor for
// counter saturation.
// -----------------------------------------------------------------------------
module tb_cache_perf_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        access_valid, clear, snap_req;
    logic [1:0]  hit_vec;
    logic [63:0] hit_cnt, miss_cnt;
    logic        busy, rate_valid, rate_nodata;
    logic [2:0]  rate_level;
    logic [6:0]  rate_pct;

    logic        a8_valid, c8_clear, s8_req;
    logic [1:0]  h8_vec;
    logic [15:0] hit8, miss8;
    logic        busy8, rate8_valid, rate8_nodata;
    logic [2:0]  rate8_level;
    logic [6:0]  rate8_pct;

    cache_perf_monitor #(.NUM_LEVELS(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .access_valid(access_valid), .hit_vec(hit_vec),
        .clear(clear), .snap_req(snap_req), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .busy(busy), .rate_valid(rate_valid), .rate_level(rate_level),
        .rate_pct(rate_pct), .rate_nodata(rate_nodata)
    );

    cache_perf_monitor #(.NUM_LEVELS(2), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .access_valid(a8_valid), .hit_vec(h8_vec),
        .clear(c8_clear), .snap_req(s8_req), .hit_cnt(hit8), .miss_cnt(miss8),
        .busy(busy8), .rate_valid(rate8_valid), .rate_level(rate8_level),
        .rate_pct(rate8_pct), .rate_nodata(rate8_nodata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pulses captured by observe(): edge index after the accepting edge.
    int         p_n;
    int         p_edge [8];
    logic [2:0] p_lvl  [8];
    logic [6:0] p_pct  [8];
    logic       p_nd   [8];
    logic       busy_hist [0:24];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [1:0] hv, input int n);
        for (int i = 0; i < n; i++) begin
            access_valid = 1'b1;
            hit_vec      = hv;
            tick();
        end
        access_valid = 1'b0;
        hit_vec      = 2'b00;
    endtask

    // Issues snap_req and records 24 edges of activity. A nonzero clear_at
    // applies clear (with a coincident access) at that edge; a nonzero
    // resnap_at raises snap_req again at that edge.
    task automatic observe(input int clear_at, input int resnap_at);
        p_n = 0;
        for (int i = 0; i < 8; i++) begin
            p_edge[i] = -1; p_lvl[i] = 3'd7; p_pct[i] = 7'h7f; p_nd[i] = 1'bx;
        end
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        busy_hist[0] = busy;
        for (int k = 1; k <= 24; k++) begin
            clear        = (k == clear_at);
            access_valid = (k == clear_at);
            hit_vec      = 2'b01;
            snap_req     = (k == resnap_at);
            tick();
            clear = 1'b0; access_valid = 1'b0; snap_req = 1'b0; hit_vec = 2'b00;
            busy_hist[k] = busy;
            if (rate_valid === 1'b1) begin
                $display("edge %0d: rate level %0d pct %0d nodata %0b", k, rate_level, rate_pct, rate_nodata);
                if (p_n < 8) begin
                    p_edge[p_n] = k; p_lvl[p_n] = rate_level;
                    p_pct[p_n] = rate_pct; p_nd[p_n] = rate_nodata;
                end
                p_n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        access_valid = 1'b0; clear = 1'b0; snap_req = 1'b0; hit_vec = 2'b00;
        a8_valid = 1'b0; c8_clear = 1'b0; s8_req = 1'b0; h8_vec = 2'b00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        $display("reset released");
        n_cmp++; if (hit_cnt !== 64'd0) begin n_bad++; $display("FAIL reset_hit: got %0h want 0", hit_cnt); end
        n_cmp++; if (miss_cnt !== 64'd0) begin n_bad++; $display("FAIL reset_miss: got %0h want 0", miss_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (rate_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", rate_valid); end
        n_cmp++; if (rate_pct !== 7'd0) begin n_bad++; $display("FAIL reset_pct: got %0d want 0", rate_pct); end
        n_cmp++; if (rate_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", rate_level); end
        n_cmp++; if (rate_nodata !== 1'b0) begin n_bad++; $display("FAIL reset_nodata: got %0b want 0", rate_nodata); end
        n_cmp++; if (hit8 !== 16'd0) begin n_bad++; $display("FAIL reset_hit8: got %0h want 0", hit8); end
    endtask

    task automatic test_nodata();
        observe(0, 0);
        n_cmp++; if (p_n !== 2) begin n_bad++; $display("FAIL nodata_count: got %0d want 2", p_n); end
        n_cmp++; if (p_edge[0] !== 9) begin n_bad++; $display("FAIL nodata_edge0: got %0d want 9", p_edge[0]); end
        n_cmp++; if (p_edge[1] !== 18) begin n_bad++; $display("FAIL nodata_edge1: got %0d want 18", p_edge[1]); end
        n_cmp++; if (p_pct[0] !== 7'd0 || p_nd[0] !== 1'b1) begin n_bad++; $display("FAIL nodata_l0: got pct %0d nd %0b want 0/1", p_pct[0], p_nd[0]); end
        n_cmp++; if (p_pct[1] !== 7'd0 || p_nd[1] !== 1'b1) begin n_bad++; $display("FAIL nodata_l1: got pct %0d nd %0b want 0/1", p_pct[1], p_nd[1]); end
    endtask

    task automatic test_counting();
        access(2'b01, 1);
        n_cmp++; if (hit_cnt[31:0] !== 32'd1) begin n_bad++; $display("FAIL latency_hit0: got %0d want 1", hit_cnt[31:0]); end
        access(2'b01, 6);
        access(2'b10, 2);
        access(2'b00, 1);
        $display("counts: hit0 %0d hit1 %0d miss0 %0d miss1 %0d", hit_cnt[31:0], hit_cnt[63:32], miss_cnt[31:0], miss_cnt[63:32]);
        n_cmp++; if (hit_cnt[31:0] !== 32'd7) begin n_bad++; $display("FAIL cnt_hit0: got %0d want 7", hit_cnt[31:0]); end
        n_cmp++; if (hit_cnt[63:32] !== 32'd2) begin n_bad++; $display("FAIL cnt_hit1: got %0d want 2", hit_cnt[63:32]); end
        n_cmp++; if (miss_cnt[31:0] !== 32'd3) begin n_bad++; $display("FAIL cnt_miss0: got %0d want 3", miss_cnt[31:0]); end
        n_cmp++; if (miss_cnt[63:32] !== 32'd1) begin n_bad++; $display("FAIL cnt_miss1: got %0d want 1", miss_cnt[63:32]); end
        observe(0, 0);
        n_cmp++; if (p_n !== 2) begin n_bad++; $display("FAIL rate_count: got %0d want 2", p_n); end
        n_cmp++; if (p_edge[0] !== 9 || p_lvl[0] !== 3'd0) begin n_bad++; $display("FAIL rate_l0_when: got edge %0d lvl %0d want 9/0", p_edge[0], p_lvl[0]); end
        n_cmp++; if (p_pct[0] !== 7'd70 || p_nd[0] !== 1'b0) begin n_bad++; $display("FAIL rate_l0_val: got %0d nd %0b want 70/0", p_pct[0], p_nd[0]); end
        n_cmp++; if (p_edge[1] !== 18 || p_lvl[1] !== 3'd1) begin n_bad++; $display("FAIL rate_l1_when: got edge %0d lvl %0d want 18/1", p_edge[1], p_lvl[1]); end
        n_cmp++; if (p_pct[1] !== 7'd66 || p_nd[1] !== 1'b0) begin n_bad++; $display("FAIL rate_l1_val: got %0d nd %0b want 66/0", p_pct[1], p_nd[1]); end
        n_cmp++; if (busy_hist[0] !== 1'b1) begin n_bad++; $display("FAIL busy_start: got %0b want 1", busy_hist[0]); end
        n_cmp++; if (busy_hist[17] !== 1'b1) begin n_bad++; $display("FAIL busy_e17: got %0b want 1", busy_hist[17]); end
        n_cmp++; if (busy_hist[18] !== 1'b0) begin n_bad++; $display("FAIL busy_e18: got %0b want 0", busy_hist[18]); end
    endtask

    task automatic test_clear();
        clear = 1'b1; access_valid = 1'b1; hit_vec = 2'b01;
        tick();
        clear = 1'b0; access_valid = 1'b0; hit_vec = 2'b00;
        $display("clear with access applied");
        n_cmp++; if (hit_cnt !== 64'd0) begin n_bad++; $display("FAIL clear_hit: got %0h want 0", hit_cnt); end
        n_cmp++; if (miss_cnt !== 64'd0) begin n_bad++; $display("FAIL clear_miss: got %0h want 0", miss_cnt); end
        access(2'b01, 3);
        access(2'b00, 1);
        observe(3, 0);
        n_cmp++; if (p_n !== 2) begin n_bad++; $display("FAIL midclr_count: got %0d want 2", p_n); end
        n_cmp++; if (p_pct[0] !== 7'd75 || p_nd[0] !== 1'b0) begin n_bad++; $display("FAIL midclr_l0: got %0d nd %0b want 75/0", p_pct[0], p_nd[0]); end
        n_cmp++; if (p_pct[1] !== 7'd0 || p_nd[1] !== 1'b0) begin n_bad++; $display("FAIL midclr_l1: got %0d nd %0b want 0/0", p_pct[1], p_nd[1]); end
        n_cmp++; if (hit_cnt !== 64'd0 || miss_cnt !== 64'd0) begin n_bad++; $display("FAIL midclr_live: got hit %0h miss %0h want 0/0", hit_cnt, miss_cnt); end
    endtask

    task automatic test_back_to_back();
        access(2'b01, 1);
        access(2'b10, 1);
        observe(0, 5);
        n_cmp++; if (p_n !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", p_n); end
        n_cmp++; if (p_edge[0] !== 9 || p_pct[0] !== 7'd50) begin n_bad++; $display("FAIL b2b_l0: got edge %0d pct %0d want 9/50", p_edge[0], p_pct[0]); end
        n_cmp++; if (p_edge[1] !== 18 || p_pct[1] !== 7'd100) begin n_bad++; $display("FAIL b2b_l1: got edge %0d pct %0d want 18/100", p_edge[1], p_pct[1]); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int busy_seen;
        access(2'b01, 2);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        $display("reset asserted during division");
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        n_cmp++; if (hit_cnt !== 64'd0 || miss_cnt !== 64'd0) begin n_bad++; $display("FAIL rstmid_cnt: got hit %0h miss %0h want 0/0", hit_cnt, miss_cnt); end
        n_cmp++; if (rate_pct !== 7'd0 || rate_level !== 3'd0) begin n_bad++; $display("FAIL rstmid_rate: got pct %0d lvl %0d want 0/0", rate_pct, rate_level); end
        tick();
        rst = 1'b0;
        pulses = 0; busy_seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (rate_valid === 1'b1) pulses++;
            if (busy === 1'b1) busy_seen++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_pulses: got %0d want 0", pulses); end
        n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL rstmid_busy_after: got %0d busy cycles want 0", busy_seen); end
    endtask

    task automatic test_saturation();
        int n8;
        int e8 [2];
        logic [6:0] pct8 [2];
        logic nd8 [2];
        logic [2:0] lv8 [2];
        for (int i = 0; i < 2; i++) begin e8[i] = -1; pct8[i] = 7'h7f; nd8[i] = 1'bx; lv8[i] = 3'd7; end
        a8_valid = 1'b1; h8_vec = 2'b01;
        repeat (300) tick();
        a8_valid = 1'b0; h8_vec = 2'b00;
        $display("8-bit counts after 300 hits: hit0 %0d miss0 %0d", hit8[7:0], miss8[7:0]);
        n_cmp++; if (hit8[7:0] !== 8'd255) begin n_bad++; $display("FAIL sat_hit0: got %0d want 255", hit8[7:0]); end
        n_cmp++; if (miss8 !== 16'd0 || hit8[15:8] !== 8'd0) begin n_bad++; $display("FAIL sat_others: got miss %0h hit1 %0d want 0/0", miss8, hit8[15:8]); end
        s8_req = 1'b1;
        tick();
        s8_req = 1'b0;
        n8 = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (rate8_valid === 1'b1) begin
                $display("edge %0d: 8-bit rate level %0d pct %0d nodata %0b", k, rate8_level, rate8_pct, rate8_nodata);
                if (n8 < 2) begin e8[n8] = k; pct8[n8] = rate8_pct; nd8[n8] = rate8_nodata; lv8[n8] = rate8_level; end
                n8++;
            end
        end
        n_cmp++; if (n8 !== 2) begin n_bad++; $display("FAIL sat_count: got %0d want 2", n8); end
        n_cmp++; if (e8[0] !== 9 || pct8[0] !== 7'd100 || nd8[0] !== 1'b0 || lv8[0] !== 3'd0) begin n_bad++; $display("FAIL sat_l0: got edge %0d pct %0d nd %0b lvl %0d want 9/100/0/0", e8[0], pct8[0], nd8[0], lv8[0]); end
        n_cmp++; if (e8[1] !== 18 || pct8[1] !== 7'd0 || nd8[1] !== 1'b1 || lv8[1] !== 3'd1) begin n_bad++; $display("FAIL sat_l1: got edge %0d pct %0d nd %0b lvl %0d want 18/0/1/1", e8[1], pct8[1], nd8[1], lv8[1]); end
    endtask

    initial begin
        test_reset();
        test_nodata();
        test_counting();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
